// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared datapath width, ALU op codes, EX FSM encoding and EX/MEM record
package riscv_pkg;

    localparam int XLEN      = 32;
    localparam int MUL_ITERS = XLEN;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9,
        ALU_MUL  = 4'd10
    } alu_op_e;

    typedef enum logic [1:0] {
        EX_IDLE = 2'd0,
        EX_MUL  = 2'd1,
        EX_DONE = 2'd2
    } ex_state_e;

    // Contents of the EX/MEM pipeline register; all-zero is a bubble.
    typedef struct packed {
        logic            valid;
        logic            reg_write;
        logic            mem_read;
        logic            mem_write;
        logic            mem_to_reg;
        logic [4:0]      rd;
        logic [XLEN-1:0] result;
        logic [XLEN-1:0] store;
    } ex_mem_t;

endpackage

// File: rtl/mul_seq.sv
// rtl/mul_seq.sv - iterative shift-add multiplier, one multiplier bit per cycle
//
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   start        : latch a/b, clear accumulator and counter, begin iterating
//   a, b         : multiplicand / multiplier (sampled only on start)
//   done         : high during the cycle whose clock edge completes the last iteration
//   product      : low XLEN bits of a*b, valid the cycle after done
module mul_seq
    import riscv_pkg::*;
(
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            done,
    output logic [XLEN-1:0] product
);

    localparam int              CW   = $clog2(MUL_ITERS);
    localparam logic [CW-1:0]   LAST = CW'(MUL_ITERS - 1);

    logic [XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0] mcand_q, mcand_d;
    logic [XLEN-1:0] mplier_q, mplier_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            run_q, run_d;

    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        run_d    = run_q;
        if (start) begin
            acc_d    = '0;
            mcand_d  = a;
            mplier_d = b;
            cnt_d    = '0;
            run_d    = 1'b1;
        end else if (run_q) begin
            // Multiplicand shifts left, multiplier shifts right; bits shifted
            // past XLEN only affect the discarded upper half of the product.
            if (mplier_q[0]) begin
                acc_d = acc_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
                run_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            run_q    <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            run_q    <= run_d;
        end
    end

    assign done    = run_q && (cnt_q == LAST);
    assign product = acc_q;

endmodule

// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - RISC-V EX stage: operand forwarding, ALU, sequential MUL, EX/MEM register
//
// Ports:
//   clk, reset_n                : clock, asynchronous active-low reset
//   valid_in, *_in controls     : instruction and control bits from ID/EX
//   alu_op                      : riscv_pkg::alu_op_e code
//   rs1/rs2_data_in, imm_in     : operands; rs1/rs2/rd_in register indices
//   mem_* / wb_*                : forwarding sources, MEM has priority over WB
//   flush                       : kill the EX instruction and any multiply in progress
//   ex_busy                     : combinational stall request for PC, IF/ID, ID/EX
//   valid_out .. rd_out         : registered EX/MEM outputs
module ex_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            valid_in,
    input  logic            RegWrite_in,
    input  logic            MemRead_in,
    input  logic            MemWrite_in,
    input  logic            MemToReg_in,
    input  logic            ALUSrc_in,
    input  logic [3:0]      alu_op,
    input  logic [XLEN-1:0] rs1_data_in,
    input  logic [XLEN-1:0] rs2_data_in,
    input  logic [XLEN-1:0] imm_in,
    input  logic [4:0]      rs1_in,
    input  logic [4:0]      rs2_in,
    input  logic [4:0]      rd_in,
    input  logic            mem_RegWrite,
    input  logic [4:0]      mem_rd,
    input  logic [XLEN-1:0] mem_result,
    input  logic            wb_RegWrite,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_result,
    input  logic            flush,
    output logic            ex_busy,
    output logic            valid_out,
    output logic            RegWrite_out,
    output logic            MemRead_out,
    output logic            MemWrite_out,
    output logic            MemToReg_out,
    output logic [XLEN-1:0] alu_result,
    output logic [XLEN-1:0] store_data,
    output logic [4:0]      rd_out
);

    import riscv_pkg::*;

    ex_state_e       state_q, state_d;
    ex_mem_t         exmem_q, exmem_d;
    logic [XLEN-1:0] fwd_a, fwd_b, op_b, alu_res;
    logic [4:0]      shamt;
    logic            busy_c;
    logic            mul_start, mul_done;
    logic [XLEN-1:0] mul_product;

    // Forwarding: MEM is younger than WB so it wins; x0 is never forwarded.
    always_comb begin
        fwd_a = rs1_data_in;
        if (mem_RegWrite && (mem_rd != 5'd0) && (mem_rd == rs1_in)) begin
            fwd_a = mem_result;
        end else if (wb_RegWrite && (wb_rd != 5'd0) && (wb_rd == rs1_in)) begin
            fwd_a = wb_result;
        end
        fwd_b = rs2_data_in;
        if (mem_RegWrite && (mem_rd != 5'd0) && (mem_rd == rs2_in)) begin
            fwd_b = mem_result;
        end else if (wb_RegWrite && (wb_rd != 5'd0) && (wb_rd == rs2_in)) begin
            fwd_b = wb_result;
        end
        op_b  = ALUSrc_in ? imm_in : fwd_b;
        shamt = op_b[4:0];
    end

    always_comb begin
        alu_res = '0;
        case (alu_op)
            ALU_ADD:  alu_res = fwd_a + op_b;
            ALU_SUB:  alu_res = fwd_a - op_b;
            ALU_AND:  alu_res = fwd_a & op_b;
            ALU_OR:   alu_res = fwd_a | op_b;
            ALU_XOR:  alu_res = fwd_a ^ op_b;
            ALU_SLL:  alu_res = fwd_a << shamt;
            ALU_SRL:  alu_res = fwd_a >> shamt;
            ALU_SRA:  alu_res = $signed(fwd_a) >>> shamt;
            ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(fwd_a) < $signed(op_b))};
            ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, (fwd_a < op_b)};
            default:  alu_res = '0;
        endcase
    end

    mul_seq u_mul_seq (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (mul_start),
        .a       (fwd_a),
        .b       (op_b),
        .done    (mul_done),
        .product (mul_product)
    );

    // Multiply sequencing: the presentation cycle and the 32 iteration cycles
    // stall the front end; DONE releases the stall and retires the product.
    always_comb begin
        state_d   = state_q;
        busy_c    = 1'b0;
        mul_start = 1'b0;
        if (flush) begin
            state_d = EX_IDLE;
        end else begin
            case (state_q)
                EX_IDLE: begin
                    if (valid_in && (alu_op == ALU_MUL)) begin
                        mul_start = 1'b1;
                        busy_c    = 1'b1;
                        state_d   = EX_MUL;
                    end
                end
                EX_MUL: begin
                    busy_c = 1'b1;
                    if (mul_done) begin
                        state_d = EX_DONE;
                    end
                end
                EX_DONE: begin
                    state_d = EX_IDLE;
                end
                default: begin
                    state_d = EX_IDLE;
                end
            endcase
        end
    end

    // EX/MEM load: bubble on flush, stall or invalid instruction; ID/EX is held
    // during a multiply so its controls are still current in DONE.
    always_comb begin
        exmem_d = '0;
        if (!flush && !busy_c && valid_in) begin
            exmem_d.valid      = 1'b1;
            exmem_d.reg_write  = RegWrite_in;
            exmem_d.mem_read   = MemRead_in;
            exmem_d.mem_write  = MemWrite_in;
            exmem_d.mem_to_reg = MemToReg_in;
            exmem_d.rd         = rd_in;
            exmem_d.store      = fwd_b;
            exmem_d.result     = (state_q == EX_DONE) ? mul_product : alu_res;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= EX_IDLE;
            exmem_q <= '0;
        end else begin
            state_q <= state_d;
            exmem_q <= exmem_d;
        end
    end

    assign ex_busy      = busy_c & reset_n;
    assign valid_out    = exmem_q.valid;
    assign RegWrite_out = exmem_q.reg_write;
    assign MemRead_out  = exmem_q.mem_read;
    assign MemWrite_out = exmem_q.mem_write;
    assign MemToReg_out = exmem_q.mem_to_reg;
    assign rd_out       = exmem_q.rd;
    assign alu_result   = exmem_q.result;
    assign store_data   = exmem_q.store;

endmodule

// File: tb/tb_ex_stage.sv
// tb/tb_ex_stage.sv - self-checking bench for ex_stage
module tb_ex_stage;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        valid_in, RegWrite_in, MemRead_in, MemWrite_in, MemToReg_in, ALUSrc_in;
    logic [3:0]  alu_op;
    logic [31:0] rs1_data_in, rs2_data_in, imm_in;
    logic [4:0]  rs1_in, rs2_in, rd_in;
    logic        mem_RegWrite, wb_RegWrite, flush;
    logic [4:0]  mem_rd, wb_rd;
    logic [31:0] mem_result, wb_result;
    logic        ex_busy, valid_out, RegWrite_out, MemRead_out, MemWrite_out, MemToReg_out;
    logic [31:0] alu_result, store_data;
    logic [4:0]  rd_out;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ex_stage #(.XLEN(32)) dut (
        .clk(clk), .reset_n(reset_n), .valid_in(valid_in),
        .RegWrite_in(RegWrite_in), .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in),
        .MemToReg_in(MemToReg_in), .ALUSrc_in(ALUSrc_in), .alu_op(alu_op),
        .rs1_data_in(rs1_data_in), .rs2_data_in(rs2_data_in), .imm_in(imm_in),
        .rs1_in(rs1_in), .rs2_in(rs2_in), .rd_in(rd_in),
        .mem_RegWrite(mem_RegWrite), .mem_rd(mem_rd), .mem_result(mem_result),
        .wb_RegWrite(wb_RegWrite), .wb_rd(wb_rd), .wb_result(wb_result),
        .flush(flush), .ex_busy(ex_busy), .valid_out(valid_out),
        .RegWrite_out(RegWrite_out), .MemRead_out(MemRead_out), .MemWrite_out(MemWrite_out),
        .MemToReg_out(MemToReg_out), .alu_result(alu_result), .store_data(store_data),
        .rd_out(rd_out)
    );

    typedef struct {
        logic [3:0]  op;
        logic        src;
        logic [4:0]  rs1, rs2;
        logic [31:0] d1, d2, imm;
        logic        mrw;
        logic [4:0]  mrd;
        logic [31:0] mres;
        logic        wrw;
        logic [4:0]  wrd;
        logic [31:0] wres;
        logic [31:0] exp;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: forwarding rule applied to the bench's current inputs.
    function automatic logic [31:0] fwd(input logic [4:0] rs, input logic [31:0] dat);
        if (mem_RegWrite && mem_rd != 5'd0 && mem_rd == rs) return mem_result;
        if (wb_RegWrite && wb_rd != 5'd0 && wb_rd == rs) return wb_result;
        return dat;
    endfunction

    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int          amt;
        int signed   sa, sb;
        longint      q;
        amt = int'(b % 32);
        sa  = a;
        sb  = b;
        case (op)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a & b;
            4'd3: return a | b;
            4'd4: return a ^ b;
            4'd5: return 32'(longint'(a) * (64'd1 << amt));
            4'd6: return 32'(longint'(a) / (64'd1 << amt));
            4'd7: begin
                // arithmetic shift = floor division by 2^amt
                q = longint'(sa) / (64'sd1 <<< amt);
                if ((longint'(sa) < 0) && (q * (64'sd1 <<< amt) != longint'(sa))) q = q - 1;
                return 32'(q);
            end
            4'd8: return (sa < sb) ? 32'd1 : 32'd0;
            4'd9: return (a < b) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    task automatic quiet_inputs();
        valid_in = 1'b0; RegWrite_in = 1'b0; MemRead_in = 1'b0; MemWrite_in = 1'b0;
        MemToReg_in = 1'b0; ALUSrc_in = 1'b0; alu_op = 4'd0;
        rs1_data_in = '0; rs2_data_in = '0; imm_in = '0;
        rs1_in = '0; rs2_in = '0; rd_in = '0;
        mem_RegWrite = 1'b0; mem_rd = '0; mem_result = '0;
        wb_RegWrite = 1'b0; wb_rd = '0; wb_result = '0;
        flush = 1'b0;
    endtask

    // Runs a full multiply from presentation to EX/MEM load. A is forwarded
    // from MEM and the MEM value is corrupted after the first edge, so the
    // product is only right if the operands were latched at start.
    task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input string tag);
        logic [31:0] expv;
        int          busy_n;
        bit          vo_bad;
        expv = a * b;
        busy_n = 0;
        vo_bad = 0;
        quiet_inputs();
        valid_in = 1'b1; alu_op = ALU_MUL; RegWrite_in = 1'b1; rd_in = 5'd17;
        rs1_in = 5'd5; rs1_data_in = 32'hDEAD_BEEF; rs2_in = 5'd6; rs2_data_in = b;
        mem_RegWrite = 1'b1; mem_rd = 5'd5; mem_result = a;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (!ex_busy) break;
            busy_n++;
            tick();
            mem_result = ~a;
            if (valid_out !== 1'b0) vo_bad = 1;
        end
        tick();
        chk({tag, "_busy_cycles"}, 32'(busy_n), 32'd33);
        chk({tag, "_bubble_while_busy"}, {31'd0, vo_bad}, 32'd0);
        chk({tag, "_valid"}, {31'd0, valid_out}, 32'd1);
        chk({tag, "_product"}, alu_result, expv);
        chk({tag, "_rd"}, {27'd0, rd_out}, 32'd17);
        quiet_inputs();
    endtask

    initial begin
        int busy_n;
        bit seen;
        logic [31:0] exp_res, exp_st;

        // Reset state, with a MUL request present to prove ex_busy is masked.
        reset_n = 1'b0;
        quiet_inputs();
        valid_in = 1'b1; alu_op = ALU_MUL;
        repeat (2) @(negedge clk);
        chk("reset_busy", {31'd0, ex_busy}, 32'd0);
        chk("reset_valid", {31'd0, valid_out}, 32'd0);
        chk("reset_result", alu_result, 32'd0);
        chk("reset_rd", {27'd0, rd_out}, 32'd0);
        quiet_inputs();
        reset_n = 1'b1;
        tick();

        // Directed single-cycle vectors
        vq.push_back('{ALU_ADD,  1'b0, 5'd5, 5'd6, 32'd1, 32'd2, 32'd0, 1'b1, 5'd5, 32'd10, 1'b1, 5'd6, 32'd3, 32'd13});
        vq.push_back('{ALU_SUB,  1'b1, 5'd0, 5'd0, 32'd0, 32'd0, 32'd4, 1'b1, 5'd0, 32'd99, 1'b0, 5'd0, 32'd0, 32'hFFFF_FFFC});
        vq.push_back('{ALU_SRA,  1'b1, 5'd1, 5'd2, 32'h8000_0000, 32'd0, 32'h21, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'hC000_0000});
        vq.push_back('{ALU_SLTU, 1'b0, 5'd1, 5'd2, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd1});
        vq.push_back('{ALU_SLT,  1'b0, 5'd1, 5'd2, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd0});
        vq.push_back('{ALU_ADD,  1'b0, 5'd7, 5'd0, 32'd100, 32'd0, 32'd0, 1'b1, 5'd7, 32'd20, 1'b1, 5'd7, 32'd30, 32'd20});
        vq.push_back('{ALU_OR,   1'b0, 5'd3, 5'd9, 32'hF0, 32'h100, 32'd0, 1'b1, 5'd4, 32'd555, 1'b1, 5'd3, 32'h0F, 32'h10F});
        vq.push_back('{ALU_XOR,  1'b0, 5'd8, 5'd2, 32'hFF, 32'h0F, 32'd0, 1'b0, 5'd8, 32'd0, 1'b0, 5'd0, 32'd0, 32'hF0});
        vq.push_back('{ALU_SLL,  1'b1, 5'd1, 5'd2, 32'd1, 32'd0, 32'd31, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'h8000_0000});
        vq.push_back('{ALU_SRL,  1'b1, 5'd1, 5'd2, 32'h8000_0000, 32'd0, 32'h3F, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd1});
        vq.push_back('{ALU_AND,  1'b0, 5'd1, 5'd2, 32'hF0F0, 32'h0FF0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'h00F0});
        vq.push_back('{ALU_SUB,  1'b0, 5'd1, 5'd2, 32'd5, 32'd7, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'hFFFF_FFFE});
        vq.push_back('{ALU_ADD,  1'b0, 5'd0, 5'd1, 32'd0, 32'd8, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'd77, 32'd8});

        for (int i = 0; i < vq.size(); i++) begin
            quiet_inputs();
            valid_in = 1'b1; RegWrite_in = 1'b1; MemToReg_in = 1'(i); rd_in = 5'(i + 1);
            alu_op = vq[i].op; ALUSrc_in = vq[i].src;
            rs1_in = vq[i].rs1; rs2_in = vq[i].rs2;
            rs1_data_in = vq[i].d1; rs2_data_in = vq[i].d2; imm_in = vq[i].imm;
            mem_RegWrite = vq[i].mrw; mem_rd = vq[i].mrd; mem_result = vq[i].mres;
            wb_RegWrite = vq[i].wrw; wb_rd = vq[i].wrd; wb_result = vq[i].wres;
            exp_st = fwd(rs2_in, rs2_data_in);
            @(negedge clk);
            chk($sformatf("vec%0d_busy", i), {31'd0, ex_busy}, 32'd0);
            tick();
            chk($sformatf("vec%0d_result", i), alu_result, vq[i].exp);
            chk($sformatf("vec%0d_store", i), store_data, exp_st);
            chk($sformatf("vec%0d_ctl", i), {27'd0, valid_out, RegWrite_out, MemRead_out, MemWrite_out, MemToReg_out},
                {27'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'(i)});
            chk($sformatf("vec%0d_rd", i), {27'd0, rd_out}, 32'(i + 1));
        end

        // Randomized single-cycle traffic against the reference model
        for (int i = 0; i < 300; i++) begin
            logic v, rw, mr, mw, mtr;
            logic [4:0] rd;
            v  = ($urandom_range(0, 3) != 0);
            rw = 1'($urandom); mr = 1'($urandom); mw = 1'($urandom); mtr = 1'($urandom);
            rd = 5'($urandom);
            valid_in = v; RegWrite_in = rw; MemRead_in = mr; MemWrite_in = mw; MemToReg_in = mtr;
            rd_in = rd;
            alu_op = 4'($urandom_range(0, 9));
            ALUSrc_in = 1'($urandom);
            rs1_in = 5'($urandom_range(0, 3)); rs2_in = 5'($urandom_range(0, 3));
            rs1_data_in = $urandom; rs2_data_in = $urandom;
            imm_in = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 63)) : $urandom;
            mem_RegWrite = 1'($urandom); mem_rd = 5'($urandom_range(0, 3)); mem_result = $urandom;
            wb_RegWrite = 1'($urandom); wb_rd = 5'($urandom_range(0, 3)); wb_result = $urandom;
            exp_st  = fwd(rs2_in, rs2_data_in);
            exp_res = ref_alu(alu_op, fwd(rs1_in, rs1_data_in), ALUSrc_in ? imm_in : exp_st);
            @(negedge clk);
            chk($sformatf("rnd%0d_busy", i), {31'd0, ex_busy}, 32'd0);
            tick();
            if (v) begin
                chk($sformatf("rnd%0d_result", i), alu_result, exp_res);
                chk($sformatf("rnd%0d_store", i), store_data, exp_st);
                chk($sformatf("rnd%0d_rd", i), {27'd0, rd_out}, {27'd0, rd});
                chk($sformatf("rnd%0d_ctl", i), {27'd0, valid_out, RegWrite_out, MemRead_out, MemWrite_out, MemToReg_out},
                    {27'd0, 1'b1, rw, mr, mw, mtr});
            end else begin
                chk($sformatf("rnd%0d_bubble", i), {28'd0, valid_out, RegWrite_out, MemRead_out, MemWrite_out}, 32'd0);
            end
        end

        // Multiply: directed plus random operands
        run_mul(32'd7, 32'hFFFF_FFFF, "mul7");
        for (int i = 0; i < 3; i++) begin
            run_mul($urandom, $urandom, $sformatf("mulrnd%0d", i));
        end

        // Flush in IDLE kills a single-cycle op and masks a MUL start
        quiet_inputs();
        valid_in = 1'b1; alu_op = ALU_ADD; RegWrite_in = 1'b1; rs1_data_in = 32'd2; flush = 1'b1;
        tick();
        chk("flush_idle_valid", {31'd0, valid_out}, 32'd0);
        alu_op = ALU_MUL;
        @(negedge clk);
        chk("flush_idle_busy", {31'd0, ex_busy}, 32'd0);
        tick();

        // Flush at multiply cycle 10
        quiet_inputs();
        valid_in = 1'b1; alu_op = ALU_MUL; rs1_data_in = 32'd7; rs2_data_in = 32'hFFFF_FFFF; RegWrite_in = 1'b1;
        repeat (9) tick();
        flush = 1'b1;
        @(negedge clk);
        chk("flush_mul_busy", {31'd0, ex_busy}, 32'd0);
        tick();
        chk("flush_mul_valid", {31'd0, valid_out}, 32'd0);
        flush = 1'b0; valid_in = 1'b0;
        @(negedge clk);
        chk("flush_after_busy", {31'd0, ex_busy}, 32'd0);
        seen = 0;
        repeat (40) begin
            tick();
            if (valid_out !== 1'b0) seen = 1;
        end
        chk("flush_no_product", {31'd0, seen}, 32'd0);
        run_mul(32'd5, 32'd6, "mul_after_flush");

        // Asynchronous reset clears a live EX/MEM entry immediately
        quiet_inputs();
        valid_in = 1'b1; alu_op = ALU_ADD; RegWrite_in = 1'b1; rd_in = 5'd9;
        rs1_data_in = 32'd40; rs2_data_in = 32'd2;
        tick();
        chk("pre_reset_result", alu_result, 32'd42);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("async_reset_out", {valid_out, RegWrite_out, MemRead_out, MemWrite_out, MemToReg_out, rd_out, 22'd0}, 32'd0);
        chk("async_reset_result", alu_result | store_data, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        tick();

        // Reset at multiply cycle 5, then a fresh multiply
        quiet_inputs();
        valid_in = 1'b1; alu_op = ALU_MUL; rs1_data_in = 32'd9; rs2_data_in = 32'd9;
        repeat (4) tick();
        @(negedge clk);
        chk("mid_mul_busy", {31'd0, ex_busy}, 32'd1);
        reset_n = 1'b0;
        #1;
        chk("mid_mul_reset_busy", {31'd0, ex_busy}, 32'd0);
        chk("mid_mul_reset_out", {valid_out, RegWrite_out, MemRead_out, MemWrite_out, MemToReg_out, rd_out, 22'd0}, 32'd0);
        chk("mid_mul_reset_data", alu_result | store_data, 32'd0);
        valid_in = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        run_mul(32'd3, 32'd4, "mul_after_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Parameters
REQ-001 XLEN, 32, datapath width; only 32 is supported.

Interface
REQ-002 clk  in  1  rising-edge clock.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 valid_in  in  1  ID/EX holds a real instruction.
REQ-005 RegWrite_in, MemRead_in, MemWrite_in, MemToReg_in, ALUSrc_in  in  1 each  control bits from ID/EX.
REQ-006 alu_op  in  4  operation code, encoded per the shared package.
REQ-007 rs1_data_in, rs2_data_in, imm_in  in  32 each  operands from ID/EX.
REQ-008 rs1_in, rs2_in, rd_in  in  5 each  register indices from ID/EX.
REQ-009 mem_RegWrite, mem_rd, mem_result  in  1/5/32  forwarding source from the MEM stage.
REQ-010 wb_RegWrite, wb_rd, wb_result  in  1/5/32  forwarding source from the WB stage.
REQ-011 flush  in  1  kills the EX instruction and any in-flight multiply.
REQ-012 ex_busy  out  1  combinational; stalls PC, IF/ID and ID/EX when high.
REQ-013 valid_out, RegWrite_out, MemRead_out, MemWrite_out, MemToReg_out  out  1 each  registered EX/MEM controls.
REQ-014 alu_result, store_data  out  32 each  registered EX/MEM data.
REQ-015 rd_out  out  5  registered EX/MEM destination register.

Function
REQ-016 Forwarded A SHALL be selected in this priority order:
- mem_result if mem_RegWrite, mem_rd!=0 and mem_rd==rs1_in;
- else wb_result under the same rule with the wb_* inputs;
- else rs1_data_in.
REQ-017 Forwarded B SHALL use the REQ-016 rule on rs2_in; store_data SHALL take forwarded B.
REQ-018 Operand B SHALL be imm_in when ALUSrc_in=1, else forwarded B.
REQ-019 Single-cycle ops SHALL be ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT, SLTU:
- shift amount is B[4:0];
- SLT is signed, SLTU is unsigned;
- result is written to EX/MEM at the next clk edge (latency 1).
REQ-020 MUL SHALL produce the low 32 bits of A*B using a shift-add iteration, 1 bit per cycle.
REQ-021 FSM states SHALL be IDLE, MUL and DONE.
REQ-022 In IDLE with valid_in=1 and alu_op=MUL, the stage SHALL latch forwarded A and B, clear the accumulator and counter, assert ex_busy, and go to MUL.
REQ-023 MUL SHALL run 32 cycles with ex_busy=1, then go to DONE.
REQ-024 DONE SHALL hold ex_busy=0, load the product and ID/EX controls into EX/MEM at the edge, and return to IDLE.
REQ-025 While ex_busy=1, EX/MEM SHALL load a bubble: valid_out, RegWrite_out, MemRead_out and MemWrite_out all 0.
REQ-026 Total MUL occupancy SHALL be 34 cycles from first presentation to the EX/MEM load.
REQ-027 valid_in=0 SHALL load a bubble regardless of the control inputs.
REQ-028 flush SHALL have highest priority: EX/MEM loads a bubble, the FSM returns to IDLE, and ex_busy is 0 that cycle.
REQ-029 rd_out SHALL equal rd_in whenever valid_out=1.

Reset
REQ-030 reset_n=0 SHALL immediately force all of the following, including mid-multiply:
- every EX/MEM output to 0;
- the FSM to IDLE;
- the counter and accumulator to 0.
REQ-031 ex_busy SHALL be 0 while reset_n=0.

Structure
REQ-032 The ALU op codes, XLEN and the FSM state encoding SHALL live in the shared package riscv_pkg.
REQ-033 The iterative multiplier SHALL be one sub-module, mul_seq, with ports start, a, b, done and product.
REQ-034 Forwarding, the ALU and the EX/MEM register SHALL remain in ex_stage.

Verification
REQ-035 Forwarding priority: ADD rs1=5, rs2=6 with mem_rd=5, mem_result=10, wb_rd=6, wb_result=3 and both RegWrite=1 -> alu_result=13 after 1 cycle.
REQ-036 x0 guard: SUB with rs1=0 and mem_rd=0, mem_RegWrite=1, mem_result=99, rs1_data_in=0, imm=4, ALUSrc=1 -> alu_result=0xFFFFFFFC.
REQ-037 MUL 7 x 0xFFFFFFFF -> ex_busy high 33 cycles, valid_out=0 throughout, then alu_result=0xFFFFFFF9 and valid_out=1 at cycle 34.
REQ-038 flush at MUL cycle 10 -> FSM in IDLE next cycle, ex_busy=0, valid_out=0, no product written.
REQ-039 reset_n low at MUL cycle 5 -> all outputs 0 immediately; after release, MUL 3 x 4 -> 12.
REQ-040 Shifts: SRA 0x80000000 by B=0x21 -> 0xC0000000; SLTU 1 vs 0xFFFFFFFF -> 1; SLT 1 vs 0xFFFFFFFF -> 0.
